rom_loader: RTL

// Downstream consumer of the sys block's ROM byte stream (rom_loading/rom_do/rom_do_valid).

---
 rtl/rom_loader.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
//  Module   : rom_loader
//  Purpose  : Consumes the sys ROM byte stream, decodes an iNES header and
//             writes the payload as 16-bit words to SDRAM via a 4-deep FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module rom_loader #(
    parameter int ADDR_W    = 22,
    parameter int BASE_ADDR = 0,
    parameter int HDR_BYTES = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rom_loading,
    input  logic [7:0]        rom_do,
    input  logic              rom_do_valid,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_ds,
    output logic              hdr_valid,
    output logic [7:0]        prg_banks,
    output logic [7:0]        chr_banks,
    output logic [7:0]        mapper,
    output logic [23:0]       byte_count,
    output logic              overflow,
    output logic              load_done
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HEADER  = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
    localparam logic [1:0] S_FLUSH   = 2'd3;

    localparam int              c_HDR_LAST = (HDR_BYTES > 0) ? HDR_BYTES - 1 : 0;
    localparam logic [ADDR_W-1:0] c_BASE   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_ADDR_MAX = '1;

    logic [1:0]        r_state;
    logic [15:0]       r_hdr_idx;
    logic [7:0]        r_magic [0:3];
    logic [3:0]        r_map_lo;
    logic [3:0]        r_map_hi;
    logic              r_hdr_check;
    logic [7:0]        r_pend;
    logic              r_pend_valid;
    logic [ADDR_W-1:0] r_addr;
    logic              r_addr_spent;

    logic              r_stg_valid;
    logic [ADDR_W-1:0] r_stg_addr;
    logic [15:0]       r_stg_data;
    logic [1:0]        r_stg_ds;

    logic [ADDR_W-1:0] r_fifo_addr [0:3];
    logic [15:0]       r_fifo_data [0:3];
    logic [1:0]        r_fifo_ds   [0:3];
    logic [1:0]        r_wr_ptr;
    logic [1:0]        r_rd_ptr;
    logic [2:0]        r_count;

    logic              w_form_valid;
    logic [15:0]       w_form_data;
    logic [1:0]        w_form_ds;
    logic              w_pop;
    logic              w_push;
    logic              w_magic_ok;

    assign mapper     = {r_map_hi, r_map_lo};
    assign w_pop      = mem_req && mem_ack;
    assign w_push     = r_stg_valid && (r_count != 3'd4);
    assign w_magic_ok = (r_magic[0] == 8'h4E) && (r_magic[1] == 8'h45) &&
                        (r_magic[2] == 8'h53) && (r_magic[3] == 8'h1A);

    // A word is formed on an odd byte, or from a lone trailing byte when loading ends.
    always_comb begin
        w_form_valid = 1'b0;
        w_form_data  = 16'h0000;
        w_form_ds    = 2'b00;
        if (r_state == S_PAYLOAD) begin
            if (rom_do_valid) begin
                if (r_pend_valid) begin
                    w_form_valid = 1'b1;
                    w_form_data  = {rom_do, r_pend};
                    w_form_ds    = 2'b11;
                end else if (!rom_loading) begin
                    w_form_valid = 1'b1;
                    w_form_data  = {8'h00, rom_do};
                    w_form_ds    = 2'b01;
                end
            end else if (!rom_loading && r_pend_valid) begin
                w_form_valid = 1'b1;
                w_form_data  = {8'h00, r_pend};
                w_form_ds    = 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_hdr_idx    <= 16'd0;
            for (int i = 0; i < 4; i++) begin
                r_magic[i]     <= 8'h00;
                r_fifo_addr[i] <= '0;
                r_fifo_data[i] <= 16'h0000;
                r_fifo_ds[i]   <= 2'b00;
            end
            r_map_lo     <= 4'h0;
            r_map_hi     <= 4'h0;
            r_hdr_check  <= 1'b0;
            r_pend       <= 8'h00;
            r_pend_valid <= 1'b0;
            r_addr       <= '0;
            r_addr_spent <= 1'b0;
            r_stg_valid  <= 1'b0;
            r_stg_addr   <= '0;
            r_stg_data   <= 16'h0000;
            r_stg_ds     <= 2'b00;
            r_wr_ptr     <= 2'd0;
            r_rd_ptr     <= 2'd0;
            r_count      <= 3'd0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 16'h0000;
            mem_ds       <= 2'b00;
            hdr_valid    <= 1'b0;
            prg_banks    <= 8'h00;
            chr_banks    <= 8'h00;
            byte_count   <= 24'd0;
            overflow     <= 1'b0;
            load_done    <= 1'b0;
        end else begin
            load_done   <= 1'b0;
            r_hdr_check <= 1'b0;
            if (r_hdr_check) hdr_valid <= w_magic_ok;

            r_stg_valid <= 1'b0;
            if (w_push) begin
                r_fifo_addr[r_wr_ptr] <= r_stg_addr;
                r_fifo_data[r_wr_ptr] <= r_stg_data;
                r_fifo_ds[r_wr_ptr]   <= r_stg_ds;
                r_wr_ptr              <= r_wr_ptr + 2'd1;
            end else if (r_stg_valid) begin
                overflow <= 1'b1;
            end
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};

            // The head entry stays queued until acknowledged, so full means 4 incl. in-flight.
            if (w_pop) begin
                mem_req  <= 1'b0;
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end else if (!mem_req && r_count != 3'd0) begin
                mem_req   <= 1'b1;
                mem_addr  <= r_fifo_addr[r_rd_ptr];
                mem_wdata <= r_fifo_data[r_rd_ptr];
                mem_ds    <= r_fifo_ds[r_rd_ptr];
            end

            if (w_form_valid) begin
                if (r_addr_spent) begin
                    overflow <= 1'b1;
                end else begin
                    r_stg_valid <= 1'b1;
                    r_stg_addr  <= r_addr;
                    r_stg_data  <= w_form_data;
                    r_stg_ds    <= w_form_ds;
                    if (r_addr == c_ADDR_MAX) r_addr_spent <= 1'b1;
                    else                      r_addr       <= r_addr + 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (rom_loading) begin
                        r_state      <= (HDR_BYTES == 0) ? S_PAYLOAD : S_HEADER;
                        for (int i = 0; i < 4; i++) r_magic[i] <= 8'h00;
                        r_map_lo     <= 4'h0;
                        r_map_hi     <= 4'h0;
                        hdr_valid    <= 1'b0;
                        prg_banks    <= 8'h00;
                        chr_banks    <= 8'h00;
                        byte_count   <= 24'd0;
                        overflow     <= 1'b0;
                        r_addr       <= c_BASE;
                        r_addr_spent <= 1'b0;
                        r_hdr_idx    <= 16'd0;
                        r_pend_valid <= 1'b0;
                    end
                end
                S_HEADER: begin
                    if (rom_do_valid) begin
                        case (r_hdr_idx)
                            16'd0:   r_magic[0] <= rom_do;
                            16'd1:   r_magic[1] <= rom_do;
                            16'd2:   r_magic[2] <= rom_do;
                            16'd3:   r_magic[3] <= rom_do;
                            16'd4:   prg_banks  <= rom_do;
                            16'd5:   chr_banks  <= rom_do;
                            16'd6:   r_map_lo   <= rom_do[7:4];
                            16'd7:   r_map_hi   <= rom_do[7:4];
                            default: ;
                        endcase
                        r_hdr_idx <= r_hdr_idx + 16'd1;
                        if (r_hdr_idx == 16'(c_HDR_LAST)) begin
                            r_state     <= S_PAYLOAD;
                            r_hdr_check <= 1'b1;
                        end
                    end
                    if (!rom_loading) r_state <= S_FLUSH;
                end
                S_PAYLOAD: begin
                    if (rom_do_valid) begin
                        if (byte_count != 24'hFFFFFF) byte_count <= byte_count + 24'd1;
                        if (r_pend_valid) begin
                            r_pend_valid <= 1'b0;
                        end else if (rom_loading) begin
                            r_pend       <= rom_do;
                            r_pend_valid <= 1'b1;
                        end
                    end
                    if (!rom_loading) begin
                        r_state      <= S_FLUSH;
                        r_pend_valid <= 1'b0;
                    end
                end
                default: begin
                    if (r_count == 3'd0 && !mem_req && !r_stg_valid) begin
                        r_state   <= S_IDLE;
                        load_done <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
